// File: rtl/scan_select_gen.sv
// scan_select_gen
//   Drives the 2-bit select pair (I1/I0) that feeds a 2-to-4 decoder, so the
//   decoder's one-hot outputs scan four digits/LEDs at a fixed rate.
//   It also provides a decoder-enable qualifier, single-step control and
//   per-digit (Tick) and per-frame (Frame) strobes.
//
//   Optional feature: define SCAN_BLANK_EN to insert a BLANK_CYC-cycle
//   blanking gap (Dec_En low) before every select change (anti-ghosting).
//
// Parameters
//   TICK_DIV  : cycles each select value is displayed (>= 2)
//   CNT_W     : prescale counter width (2**CNT_W >= TICK_DIV, BLANK_CYC)
//   BLANK_CYC : blanking gap length in cycles (SCAN_BLANK_EN only, >= 1)
//
// Ports
//   Clk    in  : clock, rising edge
//   Rst    in  : synchronous reset, active-low
//   En     in  : run enable (level)
//   Step   in  : single-step request, honoured only while idle
//   I1/I0  out : select MSB/LSB to the decoder
//   Dec_En out : decoder enable, high while the select value is displayed
//   Tick   out : one-cycle pulse when the select value changes
//   Frame  out : one-cycle pulse with Tick when the select wraps 3 -> 0
module scan_select_gen #(
    parameter int TICK_DIV  = 100000,
    parameter int CNT_W     = 17,
    parameter int BLANK_CYC = 8
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Step,
    output logic I1,
    output logic I0,
    output logic Dec_En,
    output logic Tick,
    output logic Frame
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    if (TICK_DIV < 2 || BLANK_CYC < 1 ||
        (2 ** CNT_W) < TICK_DIV || (2 ** CNT_W) < BLANK_CYC) begin : g_bad_params
        $error("scan_select_gen: illegal TICK_DIV/CNT_W/BLANK_CYC combination");
    end

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic             dec_en_q, dec_en_d;
    logic             tick_q,   tick_d;
    logic             frame_q,  frame_d;
    logic             advance;

    // Next-state / next-output logic.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (En) begin
                    state_d = ACTIVE;          // same digit, full period
                end else if (Step) begin
                    advance = 1'b1;
                end
            end

            ACTIVE: begin
                if (!En) begin
                    state_d = IDLE;            // pause wins over terminal count
                    cnt_d   = '0;
                end else if (cnt_q == TICK_LAST) begin
                    cnt_d = '0;
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;           // select holds through the gap
`else
                    advance = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!En) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ACTIVE;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            sel_d   = sel_q + 2'd1;
            tick_d  = 1'b1;
            frame_d = (sel_q == 2'd3);
        end

        // Registered from the next state so Dec_En flips on the same edge as
        // the state change (and on the same edge as Tick when leaving BLANK).
        dec_en_d = (state_d == ACTIVE);
    end

    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and is not in the sensitivity list.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            dec_en_q <= 1'b0;
            tick_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            dec_en_q <= dec_en_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
        end
    end

    assign I1     = sel_q[1];
    assign I0     = sel_q[0];
    assign Dec_En = dec_en_q;
    assign Tick   = tick_q;
    assign Frame  = frame_q;

endmodule

// File: tb/tb_scan_select_gen.sv
// Directed testbench for scan_select_gen with TICK_DIV=4, BLANK_CYC=2.
// Expected vectors are packed as {I1, I0, Dec_En, Tick, Frame}.
module tb_scan_select_gen;

    localparam int TICK_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int CNT_W     = 3;
`ifdef SCAN_BLANK_EN
    localparam int PERIOD = TICK_DIV + BLANK_CYC;
`else
    localparam int PERIOD = TICK_DIV;
`endif

    logic clk;
    logic rst_n;
    logic en;
    logic step;
    logic i1, i0, dec_en, tick, frame;

    int n_checks;
    int n_fails;

    scan_select_gen #(
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .Clk    (clk),
        .Rst    (rst_n),
        .En     (en),
        .Step   (step),
        .I1     (i1),
        .I0     (i0),
        .Dec_En (dec_en),
        .Tick   (tick),
        .Frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got {sel,de,tk,fr}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] vec(input int sel, input bit de, input bit tk, input bit fr);
        logic [1:0] s;
        s = sel[1:0];
        return {s, de, tk, fr};
    endfunction

    function automatic logic [4:0] obs();
        return {i1, i0, dec_en, tick, frame};
    endfunction

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        step  = 1'b0;

        // Reset held for 3 cycles with En high.
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check($sformatf("reset_%0d", i), obs(), vec(0, 0, 0, 0));
        end

        // Free run: edge 0 samples En=1, select steps every PERIOD edges.
        rst_n = 1'b1;
        for (int e = 0; e <= 4 * PERIOD; e++) begin
            edge_step();
            check($sformatf("run_e%0d", e), obs(),
                  vec((e / PERIOD) % 4, (e % PERIOD) < TICK_DIV,
                      (e > 0) && (e % PERIOD == 0), e == 4 * PERIOD));
        end

        // Pause/resume: restart, reach sel=2 with cnt=2, then drop En.
        rst_n = 1'b0;
        edge_step();
        check("mid_reset_clean", obs(), vec(0, 0, 0, 0));
        rst_n = 1'b1;
        edge_step();                                // edge 0: ACTIVE
        repeat (2 * PERIOD + 2) edge_step();        // sel=2, cnt=2
        check("pause_pre", obs(), vec(2, 1, 0, 0));
        en = 1'b0;
        edge_step();
        check("pause_idle", obs(), vec(2, 0, 0, 0));
        edge_step();
        check("pause_hold", obs(), vec(2, 0, 0, 0));
        en = 1'b1;
        edge_step();
        check("resume_active", obs(), vec(2, 1, 0, 0));
        repeat (PERIOD - 1) edge_step();
        check("resume_last", obs(), vec(2, (PERIOD - 1) < TICK_DIV, 0, 0));
        edge_step();
        check("resume_tick", obs(), vec(3, 1, 1, 0));

        // Single-step from IDLE with sel=3: wraps to 0 with Tick and Frame.
        en = 1'b0;
        edge_step();
        check("idle_sel3", obs(), vec(3, 0, 0, 0));
        step = 1'b1;
        edge_step();
        check("step_wrap", obs(), vec(0, 0, 1, 1));
        step = 1'b0;
        edge_step();
        check("step_release", obs(), vec(0, 0, 0, 0));
        step = 1'b1;
        edge_step();
        check("step_hold_1", obs(), vec(1, 0, 1, 0));
        edge_step();
        check("step_hold_2", obs(), vec(2, 0, 1, 0));

        // Step and En together: En wins, sel unchanged; Step ignored in ACTIVE.
        en = 1'b1;
        edge_step();
        check("step_en_prio", obs(), vec(2, 1, 0, 0));
        edge_step();
        check("step_in_active", obs(), vec(2, 1, 0, 0));
        step = 1'b0;
        edge_step();
        edge_step();                                // cnt now at terminal
        check("at_terminal", obs(), vec(2, 1, 0, 0));
        en = 1'b0;
        edge_step();
        check("en_drop_terminal", obs(), vec(2, 0, 0, 0));

        // Reset mid-run overrides En and Step.
        en = 1'b1;
        edge_step();
        check("rerun_active", obs(), vec(2, 1, 0, 0));
        rst_n = 1'b0;
        step  = 1'b1;
        edge_step();
        check("reset_mid_run", obs(), vec(0, 0, 0, 0));
        rst_n = 1'b1;
        en    = 1'b0;
        step  = 1'b0;
        edge_step();
        check("post_reset_idle", obs(), vec(0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
